// File: rtl/vga_timing.sv
// Pixel-clock raster generator: x/y scan counters, registered sync/blanking
// decode, and a frame-aligned debounced push-button level.
module vga_timing #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       Timingclk,
  input  logic       Timingreset_n,
  input  logic       button_raw,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       buttonup
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DEB_N    = 4'(DEBOUNCE_FRAMES);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       buttonup_q, buttonup_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [1:0] sync_q;
  logic       btn_s;
  logic       x_wrap, y_wrap;

  assign btn_s = sync_q[1];

  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_wrap ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : y_q + 10'd1;
    end

    // Outputs decode the next counter values so they land with the x/y they describe.
    frame_start_d = x_wrap && y_wrap;
    hsync_d       = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d       = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    video_on_d    = (x_d < H_ACT) && (y_d < V_ACT);

    // Debounce advances on the edge entering (0,0), so buttonup changes on a frame_start cycle.
    buttonup_d = buttonup_q;
    dcnt_d     = dcnt_q;
    if (frame_start_d) begin
      if (btn_s != buttonup_q) begin
        if (dcnt_q + 4'd1 == DEB_N) begin
          buttonup_d = ~buttonup_q;
          dcnt_d     = 4'd0;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end else begin
        dcnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge Timingclk or negedge Timingreset_n) begin
    if (!Timingreset_n) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
      buttonup_q    <= 1'b0;
      dcnt_q        <= 4'd0;
      sync_q        <= 2'b00;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      buttonup_q    <= buttonup_d;
      dcnt_q        <= dcnt_d;
      sync_q        <= {sync_q[0], button_raw};
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign buttonup    = buttonup_q;

endmodule

// File: tb/tb_vga_timing.sv
// Randomized button/reset stimulus on a shrunken raster, every cycle checked
// against an arithmetic model of position, sync windows and frame debounce.
module tb_vga_timing;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int DEB = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NSEG = 36;

  logic       clk;
  logic       rst_n;
  logic       raw;
  logic [9:0] x, y;
  logic       hsync, vsync, video_on, frame_start, buttonup;

  int total, bad;

  // reference model state
  int t;
  bit h1, h2;
  bit bu_m;
  int cnt_m;

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .Timingclk(clk),
    .Timingreset_n(rst_n),
    .button_raw(raw),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .frame_start(frame_start),
    .buttonup(buttonup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; h1 = 0; h2 = 0; bu_m = 0; cnt_m = 0;
  endtask

  // One clock edge with reset released: raw at this edge is the current drive.
  task automatic model_step();
    bit b;
    int mx, my;
    b  = h2;
    h2 = h1;
    h1 = raw;
    t++;
    mx = t % HT;
    my = (t / HT) % VT;
    if (mx == 0 && my == 0) begin
      if (b != bu_m) begin
        cnt_m++;
        if (cnt_m == DEB) begin
          bu_m  = ~bu_m;
          cnt_m = 0;
        end
      end else begin
        cnt_m = 0;
      end
    end
  endtask

  task automatic check_all();
    int mx, my;
    bit fs, hs_e, vs_e, vo_e;
    mx   = t % HT;
    my   = (t / HT) % VT;
    fs   = (t > 0) && (mx == 0) && (my == 0);
    hs_e = !((mx >= HA + HFP) && (mx <= HA + HFP + HS - 1));
    vs_e = !((my >= VA + VFP) && (my <= VA + VFP + VS - 1));
    vo_e = (mx < HA) && (my < VA);
    check_val("x", int'(x), mx);
    check_val("y", int'(y), my);
    check_val("hsync", int'(hsync), int'(hs_e));
    check_val("vsync", int'(vsync), int'(vs_e));
    check_val("video_on", int'(video_on), int'(vo_e));
    check_val("frame_start", int'(frame_start), int'(fs));
    check_val("buttonup", int'(buttonup), int'(bu_m));
  endtask

  task automatic check_reset_vals();
    check_val("rst_x", int'(x), 0);
    check_val("rst_y", int'(y), 0);
    check_val("rst_hsync", int'(hsync), 1);
    check_val("rst_vsync", int'(vsync), 1);
    check_val("rst_video_on", int'(video_on), 1);
    check_val("rst_frame_start", int'(frame_start), 0);
    check_val("rst_buttonup", int'(buttonup), 0);
  endtask

  initial begin
    int len;
    bit lvl, do_rst;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    raw   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst_n = 1'b1;

    for (int seg = 0; seg < NSEG; seg++) begin
      do_rst = (seg % 7 == 6);
      if (do_rst) begin
        rst_n = 1'b0;
        #1 check_reset_vals();
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1 check_reset_vals();
        end
        rst_n = 1'b1;
        model_reset();
      end
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 3) * FRAME + $urandom_range(1, FRAME);
      raw = lvl;
      $display("seg %0d raw=%0d cycles=%0d reset=%0d", seg, lvl, len, do_rst);
      for (int k = 0; k < len; k++) begin
        @(posedge clk);
        #1;
        model_step();
        check_all();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
